// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: sequences the post-reset pipeline clear,
// holds the whole pipeline while the data memory is busy, and resolves
// taken branches and load-use hazards by flushing or bubbling the
// IF/ID, ID/EX and EX/MEM pipeline registers. It also keeps saturating
// counters of stall cycles and redirect cycles.
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1_addr,
  input  logic [4:0]  id_rs2_addr,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic        pc_redirect,
  output logic        if_id_valid,
  output logic        if_id_flush,
  output logic        id_ex_valid,
  output logic        id_ex_flush,
  output logic        ex_mem_valid,
  output logic        ex_mem_flush,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t     state;
  logic [1:0] init_cnt;
  logic       mem_stall;
  logic       load_use;
  logic       hold;
  logic       in_init;

  // Hazard detection; a load into x0 never creates a dependency.
  always_comb begin
    mem_stall = mem_req & ~mem_ready;
    load_use  = ex_mem_read & (ex_rd_addr != 5'd0) &
                ((ex_rd_addr == id_rs1_addr) | (ex_rd_addr == id_rs2_addr));
  end

  // Control outputs: reset and INIT clear the pipeline, otherwise memory
  // hold beats branch redirect, which beats the load-use bubble.
  always_comb begin
    pc_en        = 1'b0;
    pc_redirect  = 1'b0;
    if_id_valid  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_valid  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_valid = 1'b0;
    ex_mem_flush = 1'b0;
    busy         = 1'b1;
    hold         = 1'b0;
    in_init      = reset | ((state != RUN) & (state != MEM_WAIT));
    if (in_init) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      busy = (state != RUN);
      hold = (state == RUN) ? mem_stall : ~mem_ready;
      if (hold) begin
        pc_en = 1'b0;
      end else if (ex_branch_taken) begin
        pc_en        = 1'b1;
        pc_redirect  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
        ex_mem_valid = 1'b1;
      end else if (load_use) begin
        id_ex_flush  = 1'b1;
        ex_mem_valid = 1'b1;
      end else begin
        pc_en        = 1'b1;
        if_id_valid  = 1'b1;
        id_ex_valid  = 1'b1;
        ex_mem_valid = 1'b1;
      end
    end
  end

  // State sequencing: four INIT cycles, then RUN, with MEM_WAIT covering
  // an outstanding data-memory access.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_cnt <= 2'd0;
    end else begin
      case (state)
        INIT: begin
          init_cnt <= init_cnt + 2'd1;
          if (init_cnt == 2'd3) state <= RUN;
        end
        RUN: begin
          if (mem_stall) state <= MEM_WAIT;
        end
        MEM_WAIT: begin
          if (mem_ready) state <= RUN;
        end
        default: begin
          state    <= INIT;
          init_cnt <= 2'd0;
        end
      endcase
    end
  end

  // Saturating performance counters; INIT cycles are not counted as stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      if (!in_init && !pc_en && (stall_cnt != 32'hFFFF_FFFF))
        stall_cnt <= stall_cnt + 32'd1;
      if (pc_redirect && (flush_cnt != 32'hFFFF_FFFF))
        flush_cnt <= flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios plus randomized
// traffic checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs1_addr;
  logic [4:0]  id_rs2_addr;
  logic [4:0]  ex_rd_addr;
  logic        ex_mem_read;
  logic        ex_branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_en;
  logic        pc_redirect;
  logic        if_id_valid;
  logic        if_id_flush;
  logic        id_ex_valid;
  logic        id_ex_flush;
  logic        ex_mem_valid;
  logic        ex_mem_flush;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
  logic        busy;

  int total = 0;
  int bad   = 0;

  // Output vector order: pc_en, pc_redirect, if_id_valid, if_id_flush,
  // id_ex_valid, id_ex_flush, ex_mem_valid, ex_mem_flush, busy
  localparam logic [8:0] V_INIT   = 9'b0_0_0_1_0_1_0_1_1;
  localparam logic [8:0] V_RUN    = 9'b1_0_1_0_1_0_1_0_0;
  localparam logic [8:0] V_BRANCH = 9'b1_1_0_1_0_1_1_0_0;
  localparam logic [8:0] V_LU     = 9'b0_0_0_0_0_1_1_0_0;
  localparam logic [8:0] V_HOLD   = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] V_WAIT   = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] V_BR_WT  = 9'b1_1_0_1_0_1_1_0_1;

  // Reference model state
  int     m_init_left = 4;
  bit     m_wait      = 0;
  longint m_stall     = 0;
  longint m_flush     = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_redirect(pc_redirect),
    .if_id_valid(if_id_valid), .if_id_flush(if_id_flush),
    .id_ex_valid(id_ex_valid), .id_ex_flush(id_ex_flush),
    .ex_mem_valid(ex_mem_valid), .ex_mem_flush(ex_mem_flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .busy(busy)
  );

  // Free-running clock, 10 time units per cycle
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] obs();
    return {pc_en, pc_redirect, if_id_valid, if_id_flush, id_ex_valid,
            id_ex_flush, ex_mem_valid, ex_mem_flush, busy};
  endfunction

  // Expected outputs from the hazard rules and the model's pipeline phase
  function automatic logic [8:0] exp_vec();
    logic lu;
    if (reset || m_init_left != 0) return V_INIT;
    lu = ex_mem_read && (ex_rd_addr != 0) &&
         (ex_rd_addr == id_rs1_addr || ex_rd_addr == id_rs2_addr);
    if (m_wait ? !mem_ready : (mem_req && !mem_ready)) return {8'b0, m_wait};
    if (ex_branch_taken) return {8'b11010110, m_wait};
    if (lu) return {8'b00000110, m_wait};
    return {8'b10101010, m_wait};
  endfunction

  // Model advance on every rising edge
  always @(posedge clk) begin
    logic [8:0] e;
    e = exp_vec();
    if (reset) begin
      m_init_left = 4;
      m_wait      = 0;
      m_stall     = 0;
      m_flush     = 0;
    end else if (m_init_left != 0) begin
      m_init_left = m_init_left - 1;
    end else begin
      if (!e[8]) m_stall = (m_stall + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_stall + 1;
      if (e[7])  m_flush = (m_flush + 1 > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_flush + 1;
      if (!m_wait && mem_req && !mem_ready) m_wait = 1;
      else if (m_wait && mem_ready) m_wait = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    id_rs1_addr = 0; id_rs2_addr = 0; ex_rd_addr = 0; ex_mem_read = 0;
    ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick();
    #1;
    total++;
    if (obs() !== V_INIT) begin bad++; $display("FAIL reset_held: got %b want %b", obs(), V_INIT); end
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (obs() !== V_INIT) begin bad++; $display("FAIL init_cycle%0d: got %b want %b", i, obs(), V_INIT); end
      tick();
    end
    #1;
    total++;
    if (obs() !== V_RUN) begin bad++; $display("FAIL first_run: got %b want %b", obs(), V_RUN); end
    total++;
    if (stall_cnt !== 0 || flush_cnt !== 0) begin
      bad++; $display("FAIL counters_after_init: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    ex_mem_read = 1; ex_rd_addr = 5; id_rs1_addr = 7; id_rs2_addr = 5;
    #1;
    total++;
    if (obs() !== V_LU) begin bad++; $display("FAIL load_use_out: got %b want %b", obs(), V_LU); end
    tick();
    total++;
    if (stall_cnt !== 1) begin bad++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
    ex_rd_addr = 0; id_rs1_addr = 0; id_rs2_addr = 0;
    #1;
    total++;
    if (obs() !== V_RUN) begin bad++; $display("FAIL x0_no_stall: got %b want %b", obs(), V_RUN); end
    tick();
    total++;
    if (stall_cnt !== 1) begin bad++; $display("FAIL x0_cnt: got %0d want 1", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_branch();
    ex_branch_taken = 1; ex_mem_read = 1; ex_rd_addr = 9; id_rs1_addr = 9;
    #1;
    total++;
    if (obs() !== V_BRANCH) begin bad++; $display("FAIL branch_out: got %b want %b", obs(), V_BRANCH); end
    tick();
    total++;
    if (flush_cnt !== 1 || stall_cnt !== 1) begin
      bad++; $display("FAIL branch_cnt: got flush=%0d stall=%0d want 1/1", flush_cnt, stall_cnt);
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    mem_req = 1; mem_ready = 0; ex_branch_taken = 1;
    #1;
    total++;
    if (obs() !== V_HOLD) begin bad++; $display("FAIL mem_stall_run: got %b want %b", obs(), V_HOLD); end
    tick();
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (obs() !== V_WAIT) begin bad++; $display("FAIL mem_wait%0d: got %b want %b", i, obs(), V_WAIT); end
      tick();
    end
    mem_ready = 1;
    #1;
    total++;
    if (obs() !== V_BR_WT) begin bad++; $display("FAIL wait_branch: got %b want %b", obs(), V_BR_WT); end
    tick();
    clear_inputs();
    #1;
    total++;
    if (obs() !== V_RUN) begin bad++; $display("FAIL after_wait: got %b want %b", obs(), V_RUN); end
    total++;
    if (stall_cnt !== 4 || flush_cnt !== 2) begin
      bad++; $display("FAIL wait_cnt: got stall=%0d flush=%0d want 4/2", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_reset_in_wait();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (stall_cnt !== 7 || busy !== 1'b1) begin
      bad++; $display("FAIL pre_reset_wait: got stall=%0d busy=%b want 7/1", stall_cnt, busy);
    end
    reset = 1;
    #1;
    total++;
    if (obs() !== V_INIT) begin bad++; $display("FAIL reset_in_wait_out: got %b want %b", obs(), V_INIT); end
    tick();
    total++;
    if (stall_cnt !== 0 || flush_cnt !== 0 || busy !== 1'b1) begin
      bad++; $display("FAIL reset_in_wait: got stall=%0d flush=%0d busy=%b want 0/0/1", stall_cnt, flush_cnt, busy);
    end
    reset = 0;
    clear_inputs();
    for (int i = 0; i < 4; i++) tick();
    #1;
    total++;
    if (obs() !== V_RUN) begin bad++; $display("FAIL run_after_reset: got %b want %b", obs(), V_RUN); end
  endtask

  task automatic test_saturation();
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    ex_mem_read = 1; ex_rd_addr = 3; id_rs1_addr = 3;
    tick();
    total++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_reach: got %h want ffffffff", stall_cnt); end
    tick();
    tick();
    total++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sat_hold: got %h want ffffffff", stall_cnt); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic [8:0] e;
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
    for (int n = 0; n < 400; n++) begin
      reset           = ($urandom_range(0, 79) == 0);
      id_rs1_addr     = 5'($urandom_range(0, 3));
      id_rs2_addr     = 5'($urandom_range(0, 3));
      ex_rd_addr      = 5'($urandom_range(0, 3));
      ex_mem_read     = 1'($urandom_range(0, 1));
      ex_branch_taken = ($urandom_range(0, 3) == 0);
      mem_req         = 1'($urandom_range(0, 1));
      mem_ready       = ($urandom_range(0, 2) != 0);
      #1;
      e = exp_vec();
      total++;
      if (obs() !== e) begin bad++; $display("FAIL rand_out[%0d]: got %b want %b", n, obs(), e); end
      total++;
      if (stall_cnt !== 32'(m_stall) || flush_cnt !== 32'(m_flush)) begin
        bad++; $display("FAIL rand_cnt[%0d]: got %0d/%0d want %0d/%0d", n, stall_cnt, flush_cnt, m_stall, m_flush);
      end
      tick();
    end
    reset = 0;
    clear_inputs();
  endtask

  // Scenario sequence and summary
  initial begin
    reset = 1;
    clear_inputs();
    @(negedge clk);
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_reset_in_wait();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
